relu_stream: RTL and testbench

- AXIS stage directly upstream of the pool module.
- Takes the conv output stream of packed signed int8 activations and applies ReLU per byte lane through a registered 2-entry skid buffer.
- Frames the stream for pooling: counts beats against the layer size from the APB configuration, generates M_AXIS_TLAST on the final beat, and reports completion via a start/done handshake.

---
 rtl/relu_stream.sv | 230 +++++++++++++++++++++++
 tb/tb_relu_stream.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stream.sv
// ---------------------------------------------------------------------------
// relu_stream
//
// Purpose:
//   AXI-Stream stage that sits in front of the pooling block. Each incoming
//   beat carries L packed signed int8 activations. Each lane is clamped at
//   zero (ReLU), and the beat then passes through a registered two-entry
//   skid buffer. The stage also frames a layer: it counts beats against
//   Flen*Flen*(num_INCH/L), regenerates TLAST on the final beat, and reports
//   completion through a level start / done handshake.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   S_AXIS_*          upstream (conv) stream; TLAST is ignored
//   M_AXIS_*          downstream (pool) stream; TLAST regenerated per layer
//   relu_start        level request from the configuration register block
//   relu_done         high while the finished layer is being acknowledged
//   Flen, num_INCH    feature-map side and channel count, latched at start
// ---------------------------------------------------------------------------
module relu_stream #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int CNT_W                  = 21
) (
   input  logic                                clk,
   input  logic                                rstn,
   output logic                                S_AXIS_TREADY,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
   input  logic                                S_AXIS_TUSER,
   input  logic                                S_AXIS_TLAST,
   input  logic                                S_AXIS_TVALID,
   input  logic                                M_AXIS_TREADY,
   output logic                                M_AXIS_TUSER,
   output logic [C_S00_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
   output logic                                M_AXIS_TLAST,
   output logic                                M_AXIS_TVALID,
   input  logic                                relu_start,
   output logic                                relu_done,
   input  logic [5:0]                          Flen,
   input  logic [8:0]                          num_INCH
);

   localparam int W  = C_S00_AXIS_TDATA_WIDTH;
   localparam int L  = W / 8;
   // One buffer entry holds {last, user, keep, data}.
   localparam int EW = W + L + 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]       state_q,   state_d;
   logic [CNT_W-1:0] total_q,   total_d;
   logic [CNT_W-1:0] in_cnt_q,  in_cnt_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic [1:0]       occ_q,     occ_d;
   logic [EW-1:0]    ent0_q,    ent0_d;   // head entry, drives M_AXIS
   logic [EW-1:0]    ent1_q,    ent1_d;   // second (skid) entry

   // ------------------------------------------------------------------
   // Layer size. 6x6 bits gives a 12-bit square, times a 9-bit group
   // count gives 21 bits, which holds 63*63*127 without overflow.
   // ------------------------------------------------------------------
   logic [11:0]      flen_sq;
   logic [8:0]       groups;
   logic [20:0]      total_wide;
   logic [CNT_W-1:0] total_calc;

   assign flen_sq    = {6'd0, Flen} * {6'd0, Flen};
   assign groups     = num_INCH / 9'(L);
   assign total_wide = {9'd0, flen_sq} * {12'd0, groups};
   assign total_calc = CNT_W'(total_wide);

   // ------------------------------------------------------------------
   // ReLU per lane: negative bytes become zero, others pass unchanged.
   // ------------------------------------------------------------------
   logic [W-1:0] relu_data;

   genvar gi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_lane
         assign relu_data[gi*8 +: 8] = S_AXIS_TDATA[gi*8+7] ? 8'h00
                                                             : S_AXIS_TDATA[gi*8 +: 8];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Handshakes. TREADY is built only from registers so upstream never
   // sees a combinational path from its own TVALID.
   // ------------------------------------------------------------------
   logic          accept;
   logic          emit;
   logic          in_last;
   logic          final_emit;
   logic [EW-1:0] in_ent;

   assign S_AXIS_TREADY = (state_q == ST_RUN) && (occ_q != 2'd2) && (in_cnt_q < total_q);
   assign accept        = S_AXIS_TREADY & S_AXIS_TVALID;
   assign M_AXIS_TVALID = (occ_q != 2'd0);
   assign emit          = M_AXIS_TVALID & M_AXIS_TREADY;

   // TLAST is decided when the beat enters, so it travels with its data.
   assign in_last    = (in_cnt_q == total_q - CNT_W'(1));
   assign final_emit = emit && (out_cnt_q == total_q - CNT_W'(1));
   assign in_ent     = {in_last, S_AXIS_TUSER, S_AXIS_TKEEP, relu_data};

   assign {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TKEEP, M_AXIS_TDATA} = ent0_q;
   assign relu_done = (state_q == ST_DONE);

   // Upstream TLAST carries no meaning here; framing is regenerated.
   logic unused_tlast;
   assign unused_tlast = S_AXIS_TLAST;

   // ------------------------------------------------------------------
   // Control FSM and beat counters
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      total_d   = total_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (relu_start) begin
               total_d   = total_calc;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               // An empty layer completes without moving any beats.
               state_d   = (total_calc == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept) begin
               in_cnt_d = in_cnt_q + CNT_W'(1);
            end
            if (emit) begin
               out_cnt_d = out_cnt_q + CNT_W'(1);
            end
            if (final_emit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Wait for the start level to drop so a held start cannot
            // immediately launch another layer.
            if (!relu_start) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Two-entry skid buffer, FIFO order, head always in ent0.
   // The head is zeroed when it drains so idle outputs read as zero.
   // ------------------------------------------------------------------
   always_comb begin
      occ_d  = occ_q;
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      if (state_q == ST_IDLE) begin
         occ_d  = 2'd0;
         ent0_d = '0;
         ent1_d = '0;
      end else begin
         case ({accept, emit})
            2'b10: begin
               if (occ_q == 2'd0) begin
                  ent0_d = in_ent;
               end else begin
                  ent1_d = in_ent;
               end
               occ_d = occ_q + 2'd1;
            end
            2'b01: begin
               if (occ_q == 2'd2) begin
                  ent0_d = ent1_q;
               end else begin
                  ent0_d = '0;
               end
               ent1_d = '0;
               occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged: the head leaves and the new beat
               // takes its place (or queues behind the skid entry).
               if (occ_q == 2'd2) begin
                  ent0_d = ent1_q;
                  ent1_d = in_ent;
               end else begin
                  ent0_d = in_ent;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         total_q   <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         occ_q     <= 2'd0;
         ent0_q    <= '0;
         ent1_q    <= '0;
      end else begin
         state_q   <= state_d;
         total_q   <= total_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         occ_q     <= occ_d;
         ent0_q    <= ent0_d;
         ent1_q    <= ent1_d;
      end
   end

endmodule

// File: tb/tb_relu_stream.sv
// ---------------------------------------------------------------------------
// tb_relu_stream
//
// Self-checking bench for relu_stream. Random upstream valid / downstream
// ready patterns are checked against a queue-based reference that applies
// ReLU arithmetically and frames beats from Flen*Flen*(num_INCH/4).
// ---------------------------------------------------------------------------
module tb_relu_stream;

   localparam int W = 32;
   localparam int L = W / 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          S_AXIS_TREADY;
   logic [W-1:0]  S_AXIS_TDATA;
   logic [L-1:0]  S_AXIS_TKEEP;
   logic          S_AXIS_TUSER;
   logic          S_AXIS_TLAST;
   logic          S_AXIS_TVALID;
   logic          M_AXIS_TREADY;
   logic          M_AXIS_TUSER;
   logic [W-1:0]  M_AXIS_TDATA;
   logic [L-1:0]  M_AXIS_TKEEP;
   logic          M_AXIS_TLAST;
   logic          M_AXIS_TVALID;
   logic          relu_start;
   logic          relu_done;
   logic [5:0]    Flen;
   logic [8:0]    num_INCH;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  fixed_data [4];
   logic          use_fixed;

   relu_stream #(
      .C_S00_AXIS_TDATA_WIDTH (W),
      .CNT_W                  (21)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .S_AXIS_TREADY (S_AXIS_TREADY),
      .S_AXIS_TDATA  (S_AXIS_TDATA),
      .S_AXIS_TKEEP  (S_AXIS_TKEEP),
      .S_AXIS_TUSER  (S_AXIS_TUSER),
      .S_AXIS_TLAST  (S_AXIS_TLAST),
      .S_AXIS_TVALID (S_AXIS_TVALID),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .M_AXIS_TUSER  (M_AXIS_TUSER),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TKEEP  (M_AXIS_TKEEP),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .relu_start    (relu_start),
      .relu_done     (relu_done),
      .Flen          (Flen),
      .num_INCH      (num_INCH)
   );

   always #5 clk = ~clk;

   // Reference ReLU: interpret each byte as a signed number, clamp at 0.
   function automatic logic [W-1:0] relu_ref(input logic [W-1:0] d);
      logic [W-1:0] r;
      int           v;
      r = '0;
      for (int i = 0; i < L; i++) begin
         v = int'($signed(d[8*i +: 8]));
         r[8*i +: 8] = (v < 0) ? 8'd0 : 8'(v);
      end
      return r;
   endfunction

   // Runs one full layer with relu_start raised. Upstream offers `offered`
   // beats with valid probability vprob (%), downstream ready probability
   // rprob (%) after `stall` forced not-ready cycles. After done, `post`
   // extra cycles are checked with relu_start still high.
   task automatic run_frame(input int flen, input int inch, input int offered,
                            input int vprob, input int rprob, input int stall,
                            input int post);
      int           total, acc, emi, cyc, done_cyc, exp_acc;
      logic [W-1:0] qd[$];
      logic [L-1:0] qk[$];
      logic         qu[$];
      logic         ql[$];
      logic         acc_now, emit_now, exp_tready, exp_tvalid, exp_done;
      total    = flen * flen * (inch / L);
      exp_acc  = (offered < total) ? offered : total;
      acc      = 0;
      emi      = 0;
      cyc      = 0;
      done_cyc = 0;
      Flen          = 6'(flen);
      num_INCH      = 9'(inch);
      relu_start    = 1'b1;
      S_AXIS_TVALID = 1'b0;
      M_AXIS_TREADY = 1'b0;
      @(posedge clk); #1;
      // Configuration must be latched; changing it now has no effect.
      Flen     = 6'($urandom);
      num_INCH = 9'($urandom);
      while (done_cyc <= post) begin
         if (!S_AXIS_TVALID && acc < offered && int'($urandom_range(99)) < vprob) begin
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = use_fixed ? fixed_data[acc % 4] : $urandom;
            S_AXIS_TKEEP  = L'($urandom);
            S_AXIS_TUSER  = 1'($urandom);
            S_AXIS_TLAST  = 1'($urandom);
         end
         M_AXIS_TREADY = (cyc < stall) ? 1'b0 : (int'($urandom_range(99)) < rprob);
         @(negedge clk);
         exp_tready = ((acc - emi) < 2) && (acc < total);
         exp_tvalid = (acc > emi);
         exp_done   = (emi == total);
         checks++;
         if (S_AXIS_TREADY !== exp_tready) begin
            errors++;
            $display("FAIL s_tready cycle %0d: got %b expected %b", cyc, S_AXIS_TREADY, exp_tready);
         end
         checks++;
         if (M_AXIS_TVALID !== exp_tvalid) begin
            errors++;
            $display("FAIL m_tvalid cycle %0d: got %b expected %b", cyc, M_AXIS_TVALID, exp_tvalid);
         end
         checks++;
         if (relu_done !== exp_done) begin
            errors++;
            $display("FAIL relu_done cycle %0d: got %b expected %b", cyc, relu_done, exp_done);
         end
         if (exp_tvalid && qd.size() > 0) begin
            checks++;
            if ({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TUSER, M_AXIS_TLAST} !==
                {qd[0], qk[0], qu[0], ql[0]}) begin
               errors++;
               $display("FAIL m_beat %0d: got data=%h keep=%h user=%b last=%b expected data=%h keep=%h user=%b last=%b",
                        emi, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TUSER, M_AXIS_TLAST,
                        qd[0], qk[0], qu[0], ql[0]);
            end
         end
         acc_now  = S_AXIS_TREADY && S_AXIS_TVALID;
         emit_now = M_AXIS_TVALID && M_AXIS_TREADY;
         if (acc_now) begin
            qd.push_back(relu_ref(S_AXIS_TDATA));
            qk.push_back(S_AXIS_TKEEP);
            qu.push_back(S_AXIS_TUSER);
            ql.push_back(acc == total - 1);
            acc++;
         end
         if (emit_now && qd.size() > 0) begin
            void'(qd.pop_front());
            void'(qk.pop_front());
            void'(qu.pop_front());
            void'(ql.pop_front());
            emi++;
         end
         if (exp_done) done_cyc++;
         @(posedge clk); #1;
         if (acc_now) S_AXIS_TVALID = 1'b0;
         cyc++;
         if (cyc > 3000) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got emitted=%0d expected emitted=%0d", emi, total);
            break;
         end
      end
      S_AXIS_TVALID = 1'b0;
      M_AXIS_TREADY = 1'b0;
      checks++;
      if (acc != exp_acc) begin
         errors++;
         $display("FAIL accepted_count: got %0d expected %0d", acc, exp_acc);
      end
      $display("frame flen=%0d inch=%0d total=%0d offered=%0d accepted=%0d emitted=%0d cycles=%0d",
               flen, inch, total, offered, acc, emi, cyc);
   endtask

   // Drops relu_start and confirms the block returns to idle.
   task automatic leave_done();
      relu_start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (relu_done !== 1'b0) begin
         errors++;
         $display("FAIL done_clear: got %b expected 0", relu_done);
      end
      checks++;
      if (S_AXIS_TREADY !== 1'b0) begin
         errors++;
         $display("FAIL idle_tready: got %b expected 0", S_AXIS_TREADY);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, relu_done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, relu_done});
      end
      checks++;
      if (M_AXIS_TDATA !== '0) begin
         errors++;
         $display("FAIL reset_tdata: got %h expected 0", M_AXIS_TDATA);
      end
      checks++;
      if (M_AXIS_TKEEP !== '0) begin
         errors++;
         $display("FAIL reset_tkeep: got %h expected 0", M_AXIS_TKEEP);
      end
      rstn = 1'b1;
      @(posedge clk); #1;
      $display("test_reset done");
   endtask

   task automatic test_basic();
      use_fixed = 1'b1;
      run_frame(2, 4, 4, 100, 100, 0, 0);
      leave_done();
      use_fixed = 1'b0;
   endtask

   task automatic test_backpressure();
      use_fixed = 1'b1;
      run_frame(2, 4, 4, 100, 100, 5, 0);
      leave_done();
      use_fixed = 1'b0;
   endtask

   task automatic test_overflow();
      // 3*3*(8/4) = 18 beats; two surplus beats must stay upstream.
      run_frame(3, 8, 20, 100, 100, 0, 3);
      leave_done();
   endtask

   task automatic test_zero();
      logic saw_ready, saw_done;
      for (int k = 0; k < 2; k++) begin
         Flen       = (k == 0) ? 6'd0 : 6'd3;
         num_INCH   = (k == 0) ? 9'd4 : 9'd0;
         relu_start = 1'b1;
         saw_ready  = 1'b0;
         saw_done   = 1'b0;
         for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (S_AXIS_TREADY === 1'b1) saw_ready = 1'b1;
            if (relu_done === 1'b1) saw_done = 1'b1;
         end
         checks++;
         if (saw_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done cfg %0d: got %b expected 1", k, saw_done);
         end
         checks++;
         if (saw_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_tready cfg %0d: got %b expected 0", k, saw_ready);
         end
         leave_done();
      end
      $display("test_zero done");
   endtask

   task automatic test_midreset();
      Flen          = 6'd2;
      num_INCH      = 9'd4;
      relu_start    = 1'b1;
      M_AXIS_TREADY = 1'b0;
      @(posedge clk); #1;
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = $urandom;
      S_AXIS_TKEEP  = 4'hF;
      S_AXIS_TUSER  = 1'b1;
      @(posedge clk); #1;
      S_AXIS_TDATA  = $urandom;
      @(posedge clk); #1;
      S_AXIS_TVALID = 1'b0;
      checks++;
      if ({M_AXIS_TVALID, S_AXIS_TREADY} !== 2'b10) begin
         errors++;
         $display("FAIL midreset_full: got valid/ready %b expected 10", {M_AXIS_TVALID, S_AXIS_TREADY});
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, relu_done} !== 5'b0) begin
         errors++;
         $display("FAIL midreset_flags: got %b expected 00000",
                  {S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, relu_done});
      end
      checks++;
      if ({M_AXIS_TDATA, M_AXIS_TKEEP} !== '0) begin
         errors++;
         $display("FAIL midreset_data: got %h/%h expected 0", M_AXIS_TDATA, M_AXIS_TKEEP);
      end
      relu_start = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      run_frame(2, 4, 4, 100, 100, 0, 0);
      leave_done();
   endtask

   task automatic test_restart();
      // Hold start high well past done: must stay in done, no new frame.
      run_frame(2, 4, 4, 80, 70, 0, 6);
      leave_done();
      run_frame(2, 8, 8, 90, 60, 2, 1);
      leave_done();
   endtask

   task automatic test_random();
      int f, c;
      for (int n = 0; n < 6; n++) begin
         f = int'($urandom_range(5, 1));
         c = 4 * int'($urandom_range(4, 1));
         run_frame(f, c, f * f * (c / L) + int'($urandom_range(3)),
                   int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                   int'($urandom_range(3)), 0);
         leave_done();
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn          = 1'b0;
      relu_start    = 1'b0;
      S_AXIS_TDATA  = '0;
      S_AXIS_TKEEP  = '0;
      S_AXIS_TUSER  = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      S_AXIS_TVALID = 1'b0;
      M_AXIS_TREADY = 1'b0;
      Flen          = '0;
      num_INCH      = '0;
      use_fixed     = 1'b0;
      fixed_data[0] = 32'h807F01FF;
      fixed_data[1] = 32'h0010F005;
      fixed_data[2] = 32'h12345678;
      fixed_data[3] = 32'hFFFFFFFF;
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_zero();
      test_midreset();
      test_restart();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
